// File: rtl/spi_pkg.sv
// Shared frame layout, FSM encoding and field helpers for the SPI frame receiver.
package spi_pkg;

    localparam int FRAME_W  = 16;
    localparam int CMD_W    = 3;
    localparam int DATA_W   = 12;
    localparam int CMD_LSB  = FRAME_W - CMD_W;
    localparam int DATA_LSB = 1;
    localparam int CNT_W    = $clog2(FRAME_W + 1);

    localparam logic [CMD_W-1:0] CMD_DAC_WRITE = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_COMMIT  = 2'd2,
        ST_WAIT_SS = 2'd3
    } state_t;

    function automatic logic [CMD_W-1:0] frame_cmd(input logic [FRAME_W-1:0] frame);
        return frame[CMD_LSB +: CMD_W];
    endfunction

    function automatic logic [DATA_W-1:0] frame_payload(input logic [FRAME_W-1:0] frame);
        return frame[DATA_LSB +: DATA_W];
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int   STAGES     = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // NOTE: sequential state always uses <=, so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{IDLE_LEVEL}};
            prev_q <= IDLE_LEVEL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 responder: deserialises 16-bit command frames onto a valid/ready port and
// echoes the last accepted frame on MISO during the next transfer.
module spi_frame_rx
    import spi_pkg::*;
#(
    parameter logic [CMD_W-1:0] CMD_EXPECT  = CMD_DAC_WRITE,
    parameter int               SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               SCLK,
    input  logic               SS,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] out_data,
    output logic [CMD_W-1:0]   out_cmd,
    output logic [DATA_W-1:0]  out_payload,
    output logic               out_cmd_ok,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               frame_err,
    output logic               overrun,
    output logic               busy
);

    logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   mosi_s;
    state_t                 state;
    logic [FRAME_W-1:0]     sr, miso_sr, echo;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   commit;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (SCLK),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // SS idles high, so its chain starts there to avoid a phantom edge out of reset.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_ss_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (SS),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mosi_sync <= '0;
        else     mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
    end

    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign commit = (state == ST_COMMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            sr        <= '0;
            bit_cnt   <= '0;
            miso_sr   <= '0;
            MISO      <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (ss_fall) begin
                        state   <= ST_SHIFT;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        sr      <= '0;
                        miso_sr <= echo;
                        MISO    <= echo[FRAME_W-1];
                    end
                end
                ST_SHIFT: begin
                    if (ss_rise) begin
                        frame_err <= (bit_cnt != '0);
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        MISO      <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            sr      <= {sr[FRAME_W-2:0], mosi_s};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == CNT_W'(FRAME_W - 1)) state <= ST_COMMIT;
                        end
                        if (sclk_fall) begin
                            miso_sr <= miso_sr << 1;
                            MISO    <= miso_sr[FRAME_W-2];
                        end
                    end
                end
                ST_COMMIT: begin
                    if (ss_rise) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        MISO  <= 1'b0;
                    end else begin
                        state <= ST_WAIT_SS;
                    end
                end
                ST_WAIT_SS: begin
                    if (ss_rise) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        MISO  <= 1'b0;
                    end else if (sclk_rise) begin
                        frame_err <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Holding register: a commit loads when the slot is free or being drained this same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data    <= '0;
            out_cmd     <= '0;
            out_payload <= '0;
            out_cmd_ok  <= 1'b0;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
            echo        <= '0;
        end else begin
            overrun <= 1'b0;
            if (commit && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (commit) begin
                out_data    <= sr;
                out_cmd     <= frame_cmd(sr);
                out_payload <= frame_payload(sr);
                out_cmd_ok  <= (frame_cmd(sr) == CMD_EXPECT);
                out_valid   <= 1'b1;
                echo        <= sr;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Self-checking bench for spi_frame_rx: directed frames plus randomized frames against a frame-level model.
module tb_spi_frame_rx;

    logic        clk, rst, SCLK, SS, MOSI, MISO;
    logic [15:0] out_data;
    logic [2:0]  out_cmd;
    logic [11:0] out_payload;
    logic        out_cmd_ok, out_valid, out_ready, frame_err, overrun, busy;

    spi_frame_rx dut (
        .clk         (clk),
        .rst         (rst),
        .SCLK        (SCLK),
        .SS          (SS),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .out_data    (out_data),
        .out_cmd     (out_cmd),
        .out_payload (out_payload),
        .out_cmd_ok  (out_cmd_ok),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  cmd;
        logic [11:0] payload;
        logic        ok;
    } rx_t;

    rx_t         got_q[$];
    logic [15:0] exp_q[$];
    int n_cmp = 0, n_fail = 0;
    int valid_cyc = 0, err_cnt = 0, ovr_cnt = 0;
    int err_m = 0, ovr_m = 0;
    logic [15:0] echo_m = '0;
    logic [15:0] held_f = '0;
    bit          held_m = 1'b0;

    always @(negedge clk) begin
        if (out_valid) valid_cyc++;
        if (out_valid && out_ready) got_q.push_back('{out_data, out_cmd, out_payload, out_cmd_ok});
        if (frame_err) err_cnt++;
        if (overrun) ovr_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frame-level model of the holding slot: ready only changes between frames.
    task automatic model_commit(input logic [15:0] f);
        if (out_ready) begin
            exp_q.push_back(f);
            echo_m = f;
        end else if (!held_m) begin
            held_m = 1'b1;
            held_f = f;
            echo_m = f;
        end else begin
            ovr_m++;
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        out_ready = v;
        if (v && held_m) begin
            exp_q.push_back(held_f);
            held_m = 1'b0;
        end
    endtask

    task automatic compare_q(input string tag);
        int n;
        logic [15:0] f;
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            f = exp_q[i];
            check($sformatf("%s_data%0d", tag, i), 64'(got_q[i].data), 64'(f));
            check($sformatf("%s_cmd%0d", tag, i), 64'(got_q[i].cmd), 64'((f >> 13) & 16'h7));
            check($sformatf("%s_pay%0d", tag, i), 64'(got_q[i].payload), 64'((f >> 1) & 16'hFFF));
            check($sformatf("%s_ok%0d", tag, i), 64'(got_q[i].ok), 64'(((f >> 13) & 16'h7) == 16'h1));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_frame_err"}, 64'(err_cnt), 64'(err_m));
        check({tag, "_overrun"}, 64'(ovr_cnt), 64'(ovr_m));
        check({tag, "_busy"}, 64'(busy), 64'h0);
    endtask

    // Drives one SPI mode-0 transfer; MISO is sampled just before each SCLK rise.
    task automatic send_frame(input logic [15:0] f, input int nbits, input bit do_rst,
                              output logic [15:0] miso_bits);
        logic [16:0] ext;
        ext       = {f, 1'b0};
        miso_bits = '0;
        SS = 1'b0;
        #80;
        for (int i = 0; i < nbits; i++) begin
            MOSI = ext[16-i];
            #40;
            if (i < 16) miso_bits[15-i] = MISO;
            SCLK = 1'b1;
            #40;
            SCLK = 1'b0;
            if (do_rst && i == 7) begin
                #20;
                rst = 1'b1;
                #1;
                check("rst_mid_outputs",
                      {27'd0, MISO, busy, out_valid, frame_err, overrun, out_cmd_ok,
                       out_data, out_cmd, out_payload}, 64'h0);
                #29;
                rst = 1'b0;
                break;
            end
        end
        #40;
        SS   = 1'b1;
        MOSI = 1'b0;
        #120;
    endtask

    task automatic xfer(input logic [15:0] f, input int nbits, input bit do_rst);
        logic [15:0] mb, mask;
        int          n_cap;
        n_cap = do_rst ? 8 : nbits;
        mask  = 16'hFFFF;
        mask  = ~(mask >> n_cap);
        send_frame(f, nbits, do_rst, mb);
        check($sformatf("miso_%04h", f), 64'(mb), 64'(echo_m & mask));
        check($sformatf("miso_idle_%04h", f), 64'(MISO), 64'h0);
        if (!do_rst) begin
            if (nbits >= 16) model_commit(f);
            if (nbits != 16 && nbits != 0) err_m++;
        end
    endtask

    initial begin
        logic [15:0] f;
        logic [15:0] mb;
        int          v0;
        rst = 1'b1; SCLK = 1'b0; SS = 1'b1; MOSI = 1'b0; out_ready = 1'b1;
        #22;
        check("reset_outputs",
              {27'd0, MISO, busy, out_valid, frame_err, overrun, out_cmd_ok,
               out_data, out_cmd, out_payload}, 64'h0);
        rst = 1'b0;
        #40;

        // 1: single DAC-write frame with consumer ready
        v0 = valid_cyc;
        xfer(16'h38AA, 16, 1'b0);
        check("t1_valid_cycles", 64'(valid_cyc - v0), 64'h1);
        check("t1_out_data", 64'(out_data), 64'h38AA);
        check("t1_out_cmd", 64'(out_cmd), 64'h1);
        check("t1_out_payload", 64'(out_payload), 64'hC55);
        check("t1_out_cmd_ok", 64'(out_cmd_ok), 64'h1);
        compare_q("t1");
        check_counts("t1");

        // 2: two frames, second with a different command
        xfer(16'h2800, 16, 1'b0);
        xfer(16'h5000, 16, 1'b0);
        check("t2_last_cmd", 64'(out_cmd), 64'h2);
        check("t2_last_ok", 64'(out_cmd_ok), 64'h0);
        compare_q("t2");
        check_counts("t2");

        // 3: SS rises after 9 bits
        v0 = valid_cyc;
        xfer(16'hA5A5, 9, 1'b0);
        check("t3_no_valid", 64'(valid_cyc - v0), 64'h0);
        compare_q("t3");
        check_counts("t3");

        // 3b: an extra SCLK edge after bit 16 flags an error but keeps the frame
        xfer(16'h3C3C, 17, 1'b0);
        compare_q("t3b");
        check_counts("t3b");

        // 4: consumer stalled, second frame overruns
        set_ready(1'b0);
        xfer(16'h3001, 16, 1'b0);
        xfer(16'h3002, 16, 1'b0);
        check("t4_valid_held", 64'(out_valid), 64'h1);
        check("t4_data_held", 64'(out_data), 64'h3001);
        check_counts("t4");
        set_ready(1'b1);
        repeat (5) @(negedge clk);
        check("t4_valid_dropped", 64'(out_valid), 64'h0);
        compare_q("t4");

        // 5: echo of an accepted frame on the next transfer
        xfer(16'h38AA, 16, 1'b0);
        check("t5_echo_model", 64'(echo_m), 64'h38AA);
        send_frame(16'h1234, 16, 1'b0, mb);
        check("t5_miso_echo", 64'(mb), 64'h38AA);
        check("t5_miso_idle", 64'(MISO), 64'h0);
        model_commit(16'h1234);
        compare_q("t5");
        check_counts("t5");

        // 6: reset mid-frame, then a clean frame; echo was cleared by reset
        xfer(16'h5555, 16, 1'b1);
        echo_m = '0;
        held_m = 1'b0;
        xfer(16'h2800, 16, 1'b0);
        compare_q("t6");
        check_counts("t6");

        // Randomized frames with random consumer readiness
        for (int k = 0; k < 12; k++) begin
            f = 16'($urandom);
            if (k % 2 == 0) f[15:13] = 3'b001;
            set_ready(1'($urandom_range(0, 1)));
            xfer(f, 16, 1'b0);
        end
        set_ready(1'b1);
        repeat (5) @(negedge clk);
        compare_q("rand");
        check_counts("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
